sync_key_decoder: RTL
=====================

// Module: sync_key_decoder
// PURPOSE
//  Parametrised successor of the line-embedded key decoder. It slices one active video line of
//  interleaved 10-bit Cb/Y/Cr/Y samples into an ID+payload bit frame, using hysteresis and a
//  3-sample majority vote per bit. The ID is checked by exact match; the payload goes to the
//  descrambler key logic. Frame alignment comes from an explicit line_start strobe, not free-running.
// PARAMETERS
//  DATA_W          10       sample width
//  BLACK_LEVEL     10'h040  nominal black code
//  WHITE_LEVEL     10'h3AC  nominal white code
//  HYST            10'h040  hysteresis offset; hi_th = WHITE_LEVEL-HYST, lo_th = BLACK_LEVEL+HYST
//  ID_BITS         8        identifier field width (sent first)
//  ID_VALUE        8'hA5    required identifier
//  PAYLOAD_BITS    32       payload width
//  SAMPLES_PER_BIT 18       luma samples per bit, >=4 (720 luma / 40 bits)
//  INTERLEAVED     1        1: only alternate samples are luma; 0: every sample is luma
//  LUMA_PHASE      1        parity of the luma sample index (index 0 = line_start sample)
// PORTS
//  clock          in   1              single clock, all logic on posedge
//  reset          in   1              synchronous, active-high
//  sample_valid   in   1              sample_in is valid this cycle
//  sample_in      in   DATA_W         video sample
//  line_start     in   1              1-cycle strobe coincident with first active sample (index 0)
//  payload_out    out  PAYLOAD_BITS   last accepted payload; holds until the next good frame
//  payload_valid  out  1              1-cycle pulse: payload_out updated
//  id_error       out  1              1-cycle pulse: frame complete, ID mismatch
//  busy           out  1              high in RECEIVE/CHECK
// BEHAVIOUR
//  - Reset: payload_out=0, payload_valid=0, id_error=0, busy=0, state IDLE, slicer LOW, all counters 0.
//  - Sample index counts valid samples from line_start (index 0). Luma: INTERLEAVED=0 -> every sample;
//    else (index&1)==LUMA_PHASE. Chroma samples are ignored entirely. Invalid cycles change nothing.
//  - Slicer, luma only: LOW->HIGH if sample_in > hi_th; HIGH->LOW if sample_in < lo_th; otherwise
//    hold (strict compares). Slicer goes LOW on line_start.
//  - Per bit, luma counter k = 0..SAMPLES_PER_BIT-1. Votes are the post-update slicer values at
//    k = M-1, M, M+1, with M = SAMPLES_PER_BIT/2. bit = majority(3). At k = SAMPLES_PER_BIT-1,
//    k wraps to 0 and the bit count increments.
//  - Shift register (ID_BITS+PAYLOAD_BITS): shifts left, new bit at LSB. The first bit ends at the
//    MSB, so ID = upper ID_BITS.
//  - FSM:
//    IDLE -> RECEIVE on line_start. Counters clear; the line_start sample is processed as index 0.
//    RECEIVE -> CHECK on the edge that takes the 3rd vote of bit ID_BITS+PAYLOAD_BITS-1.
//      The rest of that bit is not sampled.
//    CHECK -> IDLE next edge. ID==ID_VALUE: payload_out<=low PAYLOAD_BITS, payload_valid=1.
//      Otherwise id_error=1 and payload_out holds.
//    Latency: pulse is high exactly one cycle after the final vote edge.
//  - line_start in RECEIVE or CHECK: abort with no pulse, restart RECEIVE with cleared counters,
//    shift register and slicer. It takes priority over CHECK completion.
//  - reset has priority over everything, including mid-frame; no pulse is produced.
//  - Counter widths $clog2-derived; no wrap is possible inside one frame.
// TESTING
//  1 Defaults. Frame {8'hA5,32'h12345678}, bits at 0x3AC/0x040, chroma 0x200, valid every cycle
//    -> single payload_valid, payload_out=0x12345678, busy low afterward.
//  2 ID 8'h5A, payload 0xDEADBEEF after test 1 -> id_error pulse, payload_out stays 0x12345678,
//    no payload_valid.
//  3 A '1' bit with one luma sample = 0x040 at vote k=M -> bit still decoded 1 (majority).
//    A '0' bit with two vote samples = 0x3AC -> decoded 1.
//  4 After a high bit, 4 luma samples at 0x200 then 0x039 -> slicer stays HIGH through 0x200,
//    goes LOW at 0x039. 0x36D forces HIGH; 0x36C does not.
//  5 line_start at bit 20, then a full frame {A5,0x0000FFFF} -> exactly one pulse, payload 0x0000FFFF.
//    sample_valid gapped 1-of-3 -> same result.
//  6 reset at bit 30 -> all outputs 0 next cycle, no pulse. INTERLEAVED=0, SAMPLES_PER_BIT=9
//    variant repeats test 1.

Source files
------------

// File: rtl/sync_key_decoder_if.sv
// Sample/result bundle for the line-embedded key decoder.
//   master: drives sample_valid, sample_in, line_start; observes decoder results
//   slave : the decoder; consumes samples, drives payload_out, payload_valid, id_error, busy
interface sync_key_decoder_if #(
  parameter int unsigned DATA_W       = 10,
  parameter int unsigned PAYLOAD_BITS = 32
);
  logic                    sample_valid;
  logic [DATA_W-1:0]       sample_in;
  logic                    line_start;
  logic [PAYLOAD_BITS-1:0] payload_out;
  logic                    payload_valid;
  logic                    id_error;
  logic                    busy;

  modport master (
    output sample_valid, sample_in, line_start,
    input  payload_out, payload_valid, id_error, busy
  );

  modport slave (
    input  sample_valid, sample_in, line_start,
    output payload_out, payload_valid, id_error, busy
  );
endinterface

// File: rtl/sync_key_decoder.sv
// Slices one active video line into an ID+payload bit frame using a hysteresis
// slicer and a 3-vote majority per bit, then checks the ID and releases the payload.
// Ports:
//   clock - single clock, posedge
//   reset - synchronous, active-high
//   bus   - slave side: sample_valid/sample_in/line_start in,
//           payload_out/payload_valid/id_error/busy out (all registered)
module sync_key_decoder #(
  parameter int unsigned DATA_W          = 10,
  parameter int unsigned BLACK_LEVEL     = 'h040,
  parameter int unsigned WHITE_LEVEL     = 'h3AC,
  parameter int unsigned HYST            = 'h040,
  parameter int unsigned ID_BITS         = 8,
  parameter int unsigned ID_VALUE        = 'hA5,
  parameter int unsigned PAYLOAD_BITS    = 32,
  parameter int unsigned SAMPLES_PER_BIT = 18,
  parameter bit          INTERLEAVED     = 1'b1,
  parameter bit          LUMA_PHASE      = 1'b1
) (
  input logic               clock,
  input logic               reset,
  sync_key_decoder_if.slave bus
);

  localparam int unsigned FRAME_BITS = ID_BITS + PAYLOAD_BITS;
  localparam int unsigned MID        = SAMPLES_PER_BIT / 2;
  localparam int unsigned K_W        = $clog2(SAMPLES_PER_BIT);
  localparam int unsigned BC_W       = $clog2(FRAME_BITS);

  localparam logic [DATA_W-1:0]  HI_TH  = DATA_W'(WHITE_LEVEL - HYST);
  localparam logic [DATA_W-1:0]  LO_TH  = DATA_W'(BLACK_LEVEL + HYST);
  localparam logic [ID_BITS-1:0] ID_REF = ID_BITS'(ID_VALUE);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RECEIVE = 2'd1;
  localparam logic [1:0] ST_CHECK   = 2'd2;

  logic [1:0]              state_q, state_d;
  logic                    slc_q, slc_d;
  logic                    par_q, par_d;
  logic [K_W-1:0]          k_q, k_d;
  logic [BC_W-1:0]         bc_q, bc_d;
  logic                    v0_q, v0_d;
  logic                    v1_q, v1_d;
  logic [FRAME_BITS-1:0]   sh_q, sh_d;
  logic [PAYLOAD_BITS-1:0] payload_q, payload_d;
  logic                    pv_q, pv_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;

  logic                    ls;
  logic                    par_b, slc_b, is_luma, slc_new, maj;
  logic [K_W-1:0]          k_b;
  logic [BC_W-1:0]         bc_b;
  logic [FRAME_BITS-1:0]   sh_b;

  // Front end: line_start restarts the line state before the sample is applied.
  always_comb begin
    ls      = bus.line_start & bus.sample_valid;
    par_b   = ls ? 1'b0 : par_q;
    slc_b   = ls ? 1'b0 : slc_q;
    k_b     = ls ? '0 : k_q;
    bc_b    = ls ? '0 : bc_q;
    sh_b    = ls ? '0 : sh_q;
    is_luma = (INTERLEAVED == 1'b0) || (par_b == LUMA_PHASE);
    slc_new = slc_b;
    if (is_luma) begin
      if (bus.sample_in > HI_TH) begin
        slc_new = 1'b1;
      end else if (bus.sample_in < LO_TH) begin
        slc_new = 1'b0;
      end
    end
    maj = (v0_q & v1_q) | (v0_q & slc_new) | (v1_q & slc_new);
  end

  // Next-state and bit-assembly logic.
  always_comb begin
    state_d   = state_q;
    slc_d     = slc_q;
    par_d     = par_q;
    k_d       = k_q;
    bc_d      = bc_q;
    v0_d      = v0_q;
    v1_d      = v1_q;
    sh_d      = sh_q;
    payload_d = payload_q;
    pv_d      = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ls) state_d = ST_RECEIVE;
      end
      ST_RECEIVE: begin
        state_d = ST_RECEIVE;
      end
      ST_CHECK: begin
        // A new line aborts the completed frame without any pulse.
        if (ls) begin
          state_d = ST_RECEIVE;
        end else begin
          state_d = ST_IDLE;
          if (sh_q[FRAME_BITS-1 -: ID_BITS] == ID_REF) begin
            payload_d = sh_q[PAYLOAD_BITS-1:0];
            pv_d      = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.sample_valid && (ls || (state_q == ST_RECEIVE))) begin
      par_d = ~par_b;
      slc_d = slc_new;
      k_d   = k_b;
      bc_d  = bc_b;
      sh_d  = sh_b;
      if (is_luma) begin
        if (k_b == K_W'(MID - 1)) v0_d = slc_new;
        if (k_b == K_W'(MID))     v1_d = slc_new;
        // Third vote resolves the bit; the last bit ends reception immediately.
        if (k_b == K_W'(MID + 1)) begin
          sh_d = {sh_b[FRAME_BITS-2:0], maj};
          if (bc_b == BC_W'(FRAME_BITS - 1)) state_d = ST_CHECK;
        end
        if (k_b == K_W'(SAMPLES_PER_BIT - 1)) begin
          k_d  = '0;
          bc_d = bc_b + BC_W'(1);
        end else begin
          k_d = k_b + K_W'(1);
        end
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      slc_q     <= 1'b0;
      par_q     <= 1'b0;
      k_q       <= '0;
      bc_q      <= '0;
      v0_q      <= 1'b0;
      v1_q      <= 1'b0;
      sh_q      <= '0;
      payload_q <= '0;
      pv_q      <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      slc_q     <= slc_d;
      par_q     <= par_d;
      k_q       <= k_d;
      bc_q      <= bc_d;
      v0_q      <= v0_d;
      v1_q      <= v1_d;
      sh_q      <= sh_d;
      payload_q <= payload_d;
      pv_q      <= pv_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.payload_out   = payload_q;
  assign bus.payload_valid = pv_q;
  assign bus.id_error      = err_q;
  assign bus.busy          = busy_q;

endmodule
